// File: rtl/fetch_queue.sv
// fetch_queue: sequential-PC instruction fetch front end with a DEPTH-entry
// decoupling FIFO, redirect flush, and misaligned-PC fault capture.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode when the queue is empty and decode is ready.
module fetch_queue #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               ireq_valid,
    output logic [ADDR_W-1:0]  ireq_addr,
    input  logic               iresp_data_ok,
    input  logic [INSTR_W-1:0] iresp_data,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_misalign,
    output logic               ibus_not_busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               halted;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0]   mis_mem;

    logic               head_valid;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic               head_mis;

    logic               resp_take;
    logic               bypass;
    logic               idle_ok;
    logic               issue;
    logic               misalign_hit;
    logic               chain;
    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  push_pc;
    logic [INSTR_W-1:0] push_instr;
    logic               push_mis;
    logic [PTR_W-1:0]   head_nxt;
    logic [CNT_W-1:0]   cnt_after_pop;
    logic [CNT_W-1:0]   cnt_nxt;

    // Push/pop/issue decisions for the current cycle
    always_comb begin
        resp_take     = (state == WAIT) && iresp_data_ok && !redirect_valid;
        bypass        = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass        = resp_take && (count == '0) && !stall;
`endif
        idle_ok       = (state == IDLE) && !halted && (count < CNT_W'(DEPTH)) && !redirect_valid;
        issue         = idle_ok && (fetch_pc[1:0] == 2'b00);
        misalign_hit  = idle_ok && (fetch_pc[1:0] != 2'b00);
        // Re-issue straight out of WAIT so zero-wait responses sustain one per cycle
        chain         = resp_take && (count < CNT_W'(DEPTH - 1));
        push          = (resp_take && !bypass) || misalign_hit;
        push_pc       = fetch_pc;
        push_instr    = misalign_hit ? '0 : iresp_data;
        push_mis      = misalign_hit;
        pop           = (count != '0) && !stall && !redirect_valid;
        head_nxt      = head + PTR_W'(pop);
        cnt_after_pop = count - CNT_W'(pop);
        cnt_nxt       = cnt_after_pop + CNT_W'(push);
    end

    // Queue storage; contents are only observed through valid entries
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= push_pc;
            instr_mem[tail] <= push_instr;
            mis_mem[tail]   <= push_mis;
        end
    end

    // Fetch FSM, queue pointers and registered head-of-queue outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            halted     <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ireq_valid <= 1'b0;
            ireq_addr  <= '0;
            head_valid <= 1'b0;
            head_pc    <= '0;
            head_instr <= '0;
            head_mis   <= 1'b0;
        end else if (redirect_valid) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fetch_pc   <= redirect_pc;
            halted     <= 1'b0;
            head_valid <= 1'b0;
            case (state)
                WAIT, DROP: begin
                    // The old request stays on the bus until its response is swallowed
                    if (iresp_data_ok) begin
                        state      <= IDLE;
                        ireq_valid <= 1'b0;
                    end else begin
                        state      <= DROP;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            head  <= head_nxt;
            tail  <= tail + PTR_W'(push);
            count <= cnt_nxt;

            if (cnt_nxt != '0) begin
                head_valid <= 1'b1;
                if (cnt_after_pop == '0) begin
                    head_pc    <= push_pc;
                    head_instr <= push_instr;
                    head_mis   <= push_mis;
                end else begin
                    head_pc    <= pc_mem[head_nxt];
                    head_instr <= instr_mem[head_nxt];
                    head_mis   <= mis_mem[head_nxt];
                end
            end else begin
                head_valid <= 1'b0;
                if (bypass) begin
                    head_pc    <= fetch_pc;
                    head_instr <= iresp_data;
                    head_mis   <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (issue) begin
                        ireq_valid <= 1'b1;
                        ireq_addr  <= fetch_pc;
                        state      <= WAIT;
                    end
                    if (misalign_hit) begin
                        halted <= 1'b1;
                    end
                end
                WAIT: begin
                    if (iresp_data_ok) begin
                        fetch_pc <= fetch_pc + ADDR_W'(4);
                        if (chain) begin
                            ireq_addr <= fetch_pc + ADDR_W'(4);
                        end else begin
                            ireq_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (iresp_data_ok) begin
                        ireq_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_BYPASS_EN
    // Same-cycle forwarding of a response when nothing is queued ahead of it
    assign out_valid    = head_valid | bypass;
    assign out_pc       = bypass ? fetch_pc   : head_pc;
    assign out_instr    = bypass ? iresp_data : head_instr;
    assign out_misalign = bypass ? 1'b0       : head_mis;
`else
    // Decode sees registered head entry only
    assign out_valid    = head_valid;
    assign out_pc       = head_pc;
    assign out_instr    = head_instr;
    assign out_misalign = head_mis;
`endif

    assign ibus_not_busy = !ireq_valid || iresp_data_ok;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scoreboard bench for fetch_queue: an ibus responder pushes
// expected entries as it returns data; a decode-side monitor pops and compares.
module tb_fetch_queue;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;
    logic        ibus_not_busy;

    fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misalign   (out_misalign),
        .ibus_not_busy  (ibus_not_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    ent_t        exq[$];
    logic [63:0] exp_pc;
    int          req_age;
    int          lat;
    int          reqs;
    int          pops;
    bit          auto_rsp;
    bit          drop_pending;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Decode side: every accepted head entry must match the scoreboard head
    task automatic monitor();
        ent_t e;
        if (out_valid === 1'b1 && stall === 1'b0 && redirect_valid === 1'b0) begin
            checks++;
            assert (exq.size() != 0) else begin
                errors++;
                $error("FAIL out_unexpected: observed pc %h instr %h, expected no output", out_pc, out_instr);
            end
            if (exq.size() != 0) begin
                e = exq.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", {32'h0, out_instr}, {32'h0, e.instr});
                chk("out_misalign", {63'h0, out_misalign}, {63'h0, e.mis});
                pops++;
            end
        end
    endtask

    // ibus responder: answers lat cycles after a request appears, instr = pc[31:0]
    task automatic bus();
        ent_t e;
        if (ireq_valid === 1'b1) begin
            if (req_age == 0 && !drop_pending && !redirect_valid) begin
                chk("req_addr", ireq_addr, exp_pc);
                reqs++;
            end
            if (auto_rsp && req_age >= lat) begin
                iresp_data_ok = 1'b1;
                if (drop_pending || redirect_valid) begin
                    iresp_data = 32'h0000_DEAD;
                end else begin
                    iresp_data = exp_pc[31:0];
                    e.pc    = exp_pc;
                    e.instr = exp_pc[31:0];
                    e.mis   = 1'b0;
                    exq.push_back(e);
                    exp_pc  = exp_pc + 64'd4;
                end
                drop_pending = 1'b0;
                req_age      = 0;
            end else begin
                iresp_data_ok = 1'b0;
                if (redirect_valid) drop_pending = 1'b1;
                req_age++;
            end
        end else begin
            iresp_data_ok = 1'b0;
            req_age       = 0;
        end
    endtask

    task automatic cyc();
        monitor();
        bus();
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        ent_t e;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        exq.delete();
        exp_pc = pc;
        if (pc[1:0] != 2'b00) begin
            e.pc    = pc;
            e.instr = 32'h0;
            e.mis   = 1'b1;
            exq.push_back(e);
        end
        cyc();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int p0;
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        iresp_data_ok = 1'b0; iresp_data = '0;
        exp_pc = RST_PC; req_age = 0; lat = 1; reqs = 0; pops = 0;
        auto_rsp = 1'b1; drop_pending = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ireq_valid", {63'h0, ireq_valid}, 64'h0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_out_instr", {32'h0, out_instr}, 64'h0);
        chk("rst_out_misalign", {63'h0, out_misalign}, 64'h0);
        chk("rst_not_busy", {63'h0, ibus_not_busy}, 64'h1);

        // Stall until full
        stall = 1'b1;
        reset = 1'b1;
        cyc();
        chk("first_req", {63'h0, ireq_valid}, 64'h1);
        repeat (9) cyc();
        chk("full_reqs", 64'(reqs), 64'd4);
        chk("full_ireq_valid", {63'h0, ireq_valid}, 64'h0);
        chk("full_out_valid", {63'h0, out_valid}, 64'h1);
        chk("full_head_pc", out_pc, RST_PC);
        chk("full_not_busy", {63'h0, ibus_not_busy}, 64'h1);

        // Drain four entries in four cycles, fetch resumes at RESET_PC+0x10
        stall = 1'b0;
        p0 = pops;
        repeat (4) cyc();
        chk("drain_pops", 64'(pops - p0), 64'd4);

        // Sequential fetch continues in order
        p0 = pops;
        repeat (16) cyc();
        chk("seq_progress", {63'h0, (pops - p0) >= 6}, 64'h1);

        // Zero-wait responses give one request per cycle
        lat = 0;
        repeat (3) cyc();
        r0 = reqs;
        repeat (8) cyc();
        chk("throughput_reqs", 64'(reqs - r0), 64'd8);

        // Redirect with a request in flight; response 3 cycles later is dropped
        lat = 4;
        for (int i = 0; i < 10 && ireq_valid !== 1'b1; i++) cyc();
        chk("drop_wait_req", {63'h0, ireq_valid}, 64'h1);
        cyc();
        chk("busy_waiting", {63'h0, ibus_not_busy}, 64'h0);
        do_redirect(64'h8000_1000);
        repeat (3) cyc();
        chk("drop_idle", {63'h0, ireq_valid}, 64'h0);
        chk("drop_flushed", {63'h0, out_valid}, 64'h0);
        lat = 1;
        cyc();
        chk("redir_req", {63'h0, ireq_valid}, 64'h1);
        chk("redir_addr", ireq_addr, 64'h8000_1000);
        repeat (4) cyc();

        // Simultaneous redirect and data_ok with DEPTH-1 queued, one in flight, and a pop
        stall = 1'b1;
        lat = 0;
        for (int i = 0; i < 30 && exq.size() != 3; i++) cyc();
        chk("sim_fill", 64'(exq.size()), 64'd3);
        lat = 50;
        cyc();
        chk("sim_outstanding", {63'h0, ireq_valid}, 64'h1);
        stall = 1'b0;
        lat = 0;
        do_redirect(64'h8000_2000);
        chk("sim_empty", {63'h0, out_valid}, 64'h0);
        chk("sim_idle", {63'h0, ireq_valid}, 64'h0);
        lat = 1;
        cyc();
        chk("sim_req", {63'h0, ireq_valid}, 64'h1);
        chk("sim_addr", ireq_addr, 64'h8000_2000);
        repeat (3) cyc();

        // Misaligned redirect: one fault entry, no fetch until next redirect
        r0 = reqs;
        p0 = pops;
        do_redirect(64'h8000_0002);
        repeat (10) cyc();
        chk("mis_noreq", 64'(reqs - r0), 64'd0);
        chk("mis_pops", 64'(pops - p0), 64'd1);
        chk("mis_halt_ireq", {63'h0, ireq_valid}, 64'h0);
        chk("mis_halt_out", {63'h0, out_valid}, 64'h0);
        r0 = reqs;
        p0 = pops;
        do_redirect(64'h8000_0100);
        repeat (8) cyc();
        chk("mis_resume_req", {63'h0, (reqs - r0) >= 2}, 64'h1);
        chk("mis_resume_pop", {63'h0, (pops - p0) >= 1}, 64'h1);

        // Mid-transaction reset
        stall = 1'b1;
        repeat (6) cyc();
        lat = 50;
        for (int i = 0; i < 10 && ireq_valid !== 1'b1; i++) cyc();
        chk("pre_rst_req", {63'h0, ireq_valid}, 64'h1);
        chk("pre_rst_valid", {63'h0, out_valid}, 64'h1);
        #2 reset = 1'b0;
        #1;
        chk("arst_ireq_valid", {63'h0, ireq_valid}, 64'h0);
        chk("arst_ireq_addr", ireq_addr, 64'h0);
        chk("arst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("arst_out_pc", out_pc, 64'h0);
        chk("arst_out_instr", {32'h0, out_instr}, 64'h0);
        chk("arst_out_misalign", {63'h0, out_misalign}, 64'h0);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_DEAD;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        iresp_data_ok = 1'b0;
        exq.delete();
        exp_pc = RST_PC; req_age = 0; drop_pending = 1'b0;
        stall = 1'b0; lat = 1;
        chk("post_rst_req", {63'h0, ireq_valid}, 64'h1);
        chk("post_rst_addr", ireq_addr, RST_PC);
        p0 = pops;
        repeat (10) cyc();
        chk("post_rst_progress", {63'h0, (pops - p0) >= 3}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
